// File: rtl/riscv_test_monitor_pkg.sv
// Shared state encoding and default register indices for the riscv-tests pass/fail monitor.
package riscv_test_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_t;

    localparam int unsigned DEF_DONE_REG = 26;
    localparam int unsigned DEF_PASS_REG = 27;
    localparam int unsigned DEF_TNUM_REG = 3;

endpackage

// File: rtl/riscv_test_reg_snoop.sv
// Shadow copy of one architectural register, taken from the register-file write port.
module riscv_test_reg_snoop #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned IDX  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] value,
    output logic [XLEN-1:0] value_nxt,
    output logic            wr_one
);

    localparam logic [4:0] IDX5 = 5'(IDX);

    logic hit;

    // Index 0 never matches, so x0 writes are dropped and an index of 0 pins the shadow at 0.
    assign hit       = we && (IDX5 != 5'd0) && (waddr == IDX5);
    assign wr_one    = hit && (wdata == XLEN'(1));
    assign value_nxt = hit ? wdata : value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests programs: snoops done/result/test-number registers,
// waits a settle window after done, then holds a sticky verdict; includes a RUN watchdog.
module riscv_test_monitor
    import riscv_test_monitor_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned DONE_REG       = DEF_DONE_REG,
    parameter int unsigned PASS_REG       = DEF_PASS_REG,
    parameter int unsigned TNUM_REG       = DEF_TNUM_REG,
    parameter int unsigned SETTLE_CYCLES  = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_we_i,
    input  logic [4:0]       reg_waddr_i,
    input  logic [XLEN-1:0]  reg_wdata_i,
    input  logic             clear_i,
    output logic [1:0]       state_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [XLEN-1:0]  fail_testnum_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    localparam int unsigned    SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_t       state;
    logic [SW-1:0]    settle_cnt;

    logic [XLEN-1:0]  done_val, done_nxt;
    logic [XLEN-1:0]  pass_val, pass_nxt;
    logic [XLEN-1:0]  tnum_val, tnum_nxt;
    logic             done_one, pass_one, tnum_one;
    logic             pass_now;
    logic             unused_ok;

    riscv_test_reg_snoop #(.XLEN(XLEN), .IDX(DONE_REG)) u_done (
        .clk(clk), .rst(rst), .clear(clear_i),
        .we(reg_we_i), .waddr(reg_waddr_i), .wdata(reg_wdata_i),
        .value(done_val), .value_nxt(done_nxt), .wr_one(done_one)
    );

    riscv_test_reg_snoop #(.XLEN(XLEN), .IDX(PASS_REG)) u_pass (
        .clk(clk), .rst(rst), .clear(clear_i),
        .we(reg_we_i), .waddr(reg_waddr_i), .wdata(reg_wdata_i),
        .value(pass_val), .value_nxt(pass_nxt), .wr_one(pass_one)
    );

    riscv_test_reg_snoop #(.XLEN(XLEN), .IDX(TNUM_REG)) u_tnum (
        .clk(clk), .rst(rst), .clear(clear_i),
        .we(reg_we_i), .waddr(reg_waddr_i), .wdata(reg_wdata_i),
        .value(tnum_val), .value_nxt(tnum_nxt), .wr_one(tnum_one)
    );

    assign unused_ok = &{1'b0, done_val, done_nxt, pass_val, tnum_val, pass_one, tnum_one};

    // Verdict samples the post-edge shadow so a write landing on the final settle edge counts.
    assign pass_now = (pass_nxt == XLEN'(1));
    assign state_o  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_RUN;
            settle_cnt     <= '0;
            cycle_cnt_o    <= '0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            fail_o         <= 1'b0;
            timeout_o      <= 1'b0;
            fail_testnum_o <= '0;
        end else if (clear_i) begin
            state          <= ST_RUN;
            settle_cnt     <= '0;
            cycle_cnt_o    <= '0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            fail_o         <= 1'b0;
            timeout_o      <= 1'b0;
            fail_testnum_o <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
                    if (done_one) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end else if (cycle_cnt_o == TO_LAST) begin
                        state          <= ST_TIMEOUT;
                        done_o         <= 1'b1;
                        pass_o         <= 1'b0;
                        fail_o         <= 1'b1;
                        timeout_o      <= 1'b1;
                        fail_testnum_o <= tnum_nxt;
                    end
                end
                ST_SETTLE: begin
                    if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
                    if (settle_cnt == '0) begin
                        state          <= ST_DONE;
                        done_o         <= 1'b1;
                        pass_o         <= pass_now;
                        fail_o         <= !pass_now;
                        fail_testnum_o <= tnum_nxt;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed scoreboard bench for riscv_test_monitor (SETTLE_CYCLES=10, TIMEOUT_CYCLES=50).
module tb_riscv_test_monitor;

    localparam int unsigned SETTLE = 10;
    localparam int unsigned TMO    = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] reg_wdata_i;
    logic        clear_i;
    logic [1:0]  state_o;
    logic        done_o, pass_o, fail_o, timeout_o;
    logic [31:0] fail_testnum_o;
    logic [31:0] cycle_cnt_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  st;
        logic        dn;
        logic        ps;
        logic        fl;
        logic        to;
        logic [31:0] tn;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    riscv_test_monitor #(
        .XLEN(32),
        .DONE_REG(26),
        .PASS_REG(27),
        .TNUM_REG(3),
        .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .reg_we_i(reg_we_i),
        .reg_waddr_i(reg_waddr_i),
        .reg_wdata_i(reg_wdata_i),
        .clear_i(clear_i),
        .state_o(state_o),
        .done_o(done_o),
        .pass_o(pass_o),
        .fail_o(fail_o),
        .timeout_o(timeout_o),
        .fail_testnum_o(fail_testnum_o),
        .cycle_cnt_o(cycle_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_we_i    = 1'b1;
        reg_waddr_i = a;
        reg_wdata_i = d;
        tick();
        reg_we_i    = 1'b0;
        reg_waddr_i = '0;
        reg_wdata_i = '0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] st, input logic ps, input logic to,
                            input logic [31:0] tn, input logic [31:0] cnt);
        exp_t e;
        e.st  = st;
        e.dn  = 1'b1;
        e.ps  = ps;
        e.fl  = !ps;
        e.to  = to;
        e.tn  = tn;
        e.cnt = cnt;
        sbq.push_back(e);
    endtask

    task automatic check_verdict(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_state"},   64'(state_o),        64'(e.st));
            chk({tag, "_done"},    64'(done_o),         64'(e.dn));
            chk({tag, "_pass"},    64'(pass_o),         64'(e.ps));
            chk({tag, "_fail"},    64'(fail_o),         64'(e.fl));
            chk({tag, "_timeout"}, 64'(timeout_o),      64'(e.to));
            chk({tag, "_tnum"},    64'(fail_testnum_o), 64'(e.tn));
            chk({tag, "_cnt"},     64'(cycle_cnt_o),    64'(e.cnt));
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"},   64'(state_o),        64'd0);
        chk({tag, "_done"},    64'(done_o),         64'd0);
        chk({tag, "_pass"},    64'(pass_o),         64'd0);
        chk({tag, "_fail"},    64'(fail_o),         64'd0);
        chk({tag, "_timeout"}, 64'(timeout_o),      64'd0);
        chk({tag, "_tnum"},    64'(fail_testnum_o), 64'd0);
        chk({tag, "_cnt"},     64'(cycle_cnt_o),    64'd0);
    endtask

    // Pass flag at edge 1, trigger at edge 20, verdict exactly SETTLE edges later.
    task automatic scenario1(input string tag);
        wr(5'd27, 32'd1);
        idle(18);
        wr(5'd26, 32'd1);
        push_exp(2'd2, 1'b1, 1'b0, 32'd0, 32'd30);
        chk({tag, "_settle_state"}, 64'(state_o), 64'd1);
        chk({tag, "_settle_cnt"},   64'(cycle_cnt_o), 64'd20);
        idle(SETTLE - 1);
        chk({tag, "_early_done"},   64'(done_o), 64'd0);
        chk({tag, "_early_state"},  64'(state_o), 64'd1);
        tick();
        check_verdict(tag);
    endtask

    initial begin
        rst         = 1'b0;
        reg_we_i    = 1'b0;
        reg_waddr_i = '0;
        reg_wdata_i = '0;
        clear_i     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        #3 rst = 1'b1;

        scenario1("t1");

        // Fail verdict with test number, then sticky hold with frozen counter.
        do_clear();
        check_idle("t2_clear");
        wr(5'd3, 32'd7);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        push_exp(2'd2, 1'b0, 1'b0, 32'd7, 32'd13);
        push_exp(2'd2, 1'b0, 1'b0, 32'd7, 32'd13);
        idle(SETTLE);
        check_verdict("t2");
        idle(100);
        check_verdict("t2_hold");

        // Pass write on the final settle edge counts.
        do_clear();
        idle(4);
        wr(5'd26, 32'd1);
        push_exp(2'd2, 1'b1, 1'b0, 32'd0, 32'd15);
        idle(SETTLE - 1);
        wr(5'd27, 32'd1);
        check_verdict("t3a");

        // Pass write one edge after the verdict is too late.
        do_clear();
        idle(4);
        wr(5'd26, 32'd1);
        push_exp(2'd2, 1'b0, 1'b0, 32'd0, 32'd15);
        idle(SETTLE);
        check_verdict("t3b");
        wr(5'd27, 32'd1);
        chk("t3b_late_pass", 64'(pass_o), 64'd0);
        wr(5'd26, 32'd0);
        chk("t3b_late_done_state", 64'(state_o), 64'd2);

        // Watchdog expiry with no writes.
        do_clear();
        idle(TMO - 1);
        chk("t4a_pre_state",   64'(state_o),   64'd0);
        chk("t4a_pre_timeout", 64'(timeout_o), 64'd0);
        push_exp(2'd3, 1'b0, 1'b1, 32'd0, 32'd50);
        push_exp(2'd3, 1'b0, 1'b1, 32'd0, 32'd50);
        tick();
        check_verdict("t4a");
        idle(5);
        check_verdict("t4a_hold");

        // Trigger on the timeout edge wins.
        do_clear();
        idle(TMO - 1);
        wr(5'd26, 32'd1);
        chk("t4b_state",   64'(state_o),   64'd1);
        chk("t4b_timeout", 64'(timeout_o), 64'd0);
        push_exp(2'd2, 1'b0, 1'b0, 32'd0, 32'd60);
        idle(SETTLE);
        check_verdict("t4b");

        // x0 writes and non-1 done values do not trigger; clear beats a simultaneous trigger.
        do_clear();
        wr(5'd3, 32'd5);
        wr(5'd0, 32'd1);
        wr(5'd26, 32'd2);
        idle(2);
        chk("t5_notrig_state", 64'(state_o), 64'd0);
        chk("t5_notrig_cnt",   64'(cycle_cnt_o), 64'd5);
        reg_we_i    = 1'b1;
        reg_waddr_i = 5'd26;
        reg_wdata_i = 32'd1;
        clear_i     = 1'b1;
        tick();
        reg_we_i    = 1'b0;
        reg_waddr_i = '0;
        reg_wdata_i = '0;
        clear_i     = 1'b0;
        chk("t5_clr_state", 64'(state_o), 64'd0);
        chk("t5_clr_cnt",   64'(cycle_cnt_o), 64'd0);
        tick();
        chk("t5_next_state", 64'(state_o), 64'd0);
        chk("t5_next_cnt",   64'(cycle_cnt_o), 64'd1);
        wr(5'd26, 32'd1);
        push_exp(2'd2, 1'b0, 1'b0, 32'd0, 32'd12);
        idle(SETTLE);
        check_verdict("t5_tnum_cleared");

        // Asynchronous reset mid-settle, then a clean rerun.
        do_clear();
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        idle(3);
        chk("t6_pre_state", 64'(state_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_idle("t6_async");
        idle(2);
        #3 rst = 1'b1;
        scenario1("t6_rerun");

        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
